mac_spike_scheduler: RTL

- Controller that sequences the single accumulating floating-point adder inside a neuron's MAC.
- Holds one 32-bit synaptic weight per spike input, latched during initialisation.
- Accepts a vector of up to NUM_SRC simultaneous input spikes and serialises their weights onto the adder, one per cycle.
- At timestep end it drains the adder pipeline, captures the membrane potential, then clears the accumulator.

---
 rtl/mac_pkg.sv | 10 +
 rtl/lsb_priority_picker.sv | 15 +
 rtl/mac_spike_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, constants and state encoding for the MAC spike scheduler.
package mac_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 8;
  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CAPTURE, S_CLEAR} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + CNT_W'(1);
  endfunction
endpackage

// File: rtl/lsb_priority_picker.sv
// lsb_priority_picker: one-hot grant and index of the lowest set bit of a mask.
module lsb_priority_picker #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  assign grant = mask & (~mask + N'(1));
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = mask[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/mac_spike_scheduler.sv
// mac_spike_scheduler: serialises spike weights onto a MAC adder and captures the potential per timestep.
module mac_spike_scheduler
  import mac_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ADD_LAT = 2,
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [DATA_W-1:0]  cfg_weight,
  input  logic [NUM_SRC-1:0] spike_vec,
  input  logic               spike_valid,
  output logic               spike_ready,
  input  logic               timestep_end,
  input  logic [DATA_W-1:0]  acc_value,
  output logic [DATA_W-1:0]  weight_out,
  output logic               weight_valid,
  output logic               acc_clear,
  output logic [DATA_W-1:0]  potential_out,
  output logic               potential_valid,
  output logic [CNT_W-1:0]   spike_count,
  output logic               busy
);
  localparam int DW = $clog2(ADD_LAT + 2);
  state_t              state;
  logic [DATA_W-1:0]   weight [NUM_SRC];
  logic [NUM_SRC-1:0]  pending, grant;
  logic [IDX_W-1:0]    pick;
  logic [DW-1:0]       dcnt;
  logic                ts_pending, last, accept, ts_now;
  lsb_priority_picker #(.N(NUM_SRC)) u_pick (.mask(pending), .grant(grant), .idx(pick));
  assign last   = (pending & ~grant) == '0;
  assign accept = spike_valid & spike_ready;
  assign ts_now = ts_pending | timestep_end;
  assign busy   = state != S_IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      weight          <= '{default: FP_ZERO};
      pending         <= '0;
      ts_pending      <= 1'b0;
      dcnt            <= '0;
      spike_ready     <= 1'b0;
      weight_out      <= FP_ZERO;
      weight_valid    <= 1'b0;
      acc_clear       <= 1'b0;
      potential_out   <= FP_ZERO;
      potential_valid <= 1'b0;
      spike_count     <= '0;
    end else begin
      weight_out      <= FP_ZERO;
      weight_valid    <= 1'b0;
      acc_clear       <= 1'b0;
      potential_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          spike_ready <= 1'b1;
          if (set) weight[cfg_idx] <= cfg_weight;
          // a zero vector is consumed here but does not leave IDLE
          if (accept && |spike_vec) begin
            pending     <= spike_vec;
            ts_pending  <= timestep_end;
            state       <= S_ISSUE;
            spike_ready <= 1'b0;
          end else if (timestep_end) begin
            state       <= S_DRAIN;
            spike_ready <= 1'b0;
          end
        end
        S_ISSUE: begin
          weight_out   <= weight[pick];
          weight_valid <= 1'b1;
          pending      <= pending & ~grant;
          spike_count  <= sat_inc(spike_count);
          ts_pending   <= ts_now;
          if (last) begin
            state       <= ts_now ? S_DRAIN : S_IDLE;
            spike_ready <= !ts_now;
          end
        end
        S_DRAIN: begin
          dcnt  <= (dcnt == DW'(ADD_LAT)) ? '0 : dcnt + DW'(1);
          state <= (dcnt == DW'(ADD_LAT)) ? S_CAPTURE : S_DRAIN;
        end
        S_CAPTURE: begin
          potential_out   <= acc_value;
          potential_valid <= 1'b1;
          state           <= S_CLEAR;
        end
        S_CLEAR: begin
          acc_clear   <= 1'b1;
          spike_count <= '0;
          ts_pending  <= 1'b0;
          spike_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
